// File: rtl/gated_event_counter_if.sv
// Control and result bundle for gated_event_counter: window request/config
// and the asynchronous event input in, busy/done/count/overflow out.
interface gated_event_counter_if #(
  parameter int WIDTH  = 8,
  parameter int GATE_W = 16
);
  logic              start;
  logic              cont;
  logic [GATE_W-1:0] gate_len;
  logic              evt_in;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  count;
  logic              overflow;

  modport master (
    output start, cont, gate_len, evt_in,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, cont, gate_len, evt_in,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/gated_event_counter.sv
// Gated event counter: synchronises an asynchronous event line, counts its
// rising edges over a window of gate_len clocks, and latches a saturating
// total with a one-cycle done strobe. Optional back-to-back (cont) windows.
module gated_event_counter #(
  parameter int WIDTH  = 8,
  parameter int GATE_W = 16
) (
  input logic               clk,
  input logic               rst,
  gated_event_counter_if.slave bus
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [WIDTH-1:0]  ACC_MAX = '1;
  localparam logic [WIDTH-1:0]  ACC_ONE = WIDTH'(1);
  localparam logic [GATE_W-1:0] REM_ONE = GATE_W'(1);

  state_t            state;
  logic              s1, s2, s3;
  logic              evt_edge;
  logic [GATE_W-1:0] rem;
  logic [WIDTH-1:0]  acc;
  logic              ovf_int;
  logic              acc_full;
  logic [WIDTH-1:0]  acc_next;
  logic              ovf_next;

  // Edge pulse and the accumulator/overflow values after this cycle's edge.
  always_comb begin
    evt_edge = s2 & ~s3;
    acc_full = (acc == ACC_MAX);
    acc_next = acc;
    ovf_next = ovf_int;
    if (evt_edge) begin
      if (acc_full) ovf_next = 1'b1;
      else          acc_next = acc + ACC_ONE;
    end
  end

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Window control FSM with registered busy/done/count/overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rem          <= '0;
      acc          <= '0;
      ovf_int      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.gate_len != '0) begin
              rem      <= bus.gate_len;
              acc      <= '0;
              ovf_int  <= 1'b0;
              bus.busy <= 1'b1;
              state    <= COUNT;
            end else begin
              bus.count    <= '0;
              bus.overflow <= 1'b0;
              bus.done     <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (rem == REM_ONE) begin
            // Final edge is folded straight into the latched result.
            bus.count    <= acc_next;
            bus.overflow <= ovf_next;
            bus.done     <= 1'b1;
            if (bus.cont && (bus.gate_len != '0)) begin
              rem     <= bus.gate_len;
              acc     <= '0;
              ovf_int <= 1'b0;
            end else begin
              rem      <= '0;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            rem     <= rem - REM_ONE;
            acc     <= acc_next;
            ovf_int <= ovf_next;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gated_event_counter.sv
// Self-checking bench for gated_event_counter: directed scenarios plus
// randomized traffic, compared every cycle against a window-level model.
module tb_gated_event_counter;

  localparam int WIDTH  = 4;
  localparam int GATE_W = 8;
  localparam int MAXC   = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  gated_event_counter_if #(.WIDTH(WIDTH), .GATE_W(GATE_W)) bus ();

  gated_event_counter #(.WIDTH(WIDTH), .GATE_W(GATE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  // Reference model: history of sampled evt_in values, unsaturated hit
  // count per window, saturation applied only when the result is latched.
  int hist[$];
  int m_busy, m_left, m_hits, m_count, m_ovf, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist    = '{0, 0, 0};
    m_busy  = 0;
    m_left  = 0;
    m_hits  = 0;
    m_count = 0;
    m_ovf   = 0;
    m_done  = 0;
  endtask

  task automatic model_step();
    int e;
    if (!rst) begin
      model_reset();
      return;
    end
    // A rise sampled two posedges ago is seen as an edge now.
    e = (hist[1] == 1 && hist[2] == 0) ? 1 : 0;
    hist.push_front(int'(bus.evt_in));
    void'(hist.pop_back());
    m_done = 0;
    if (m_busy == 0) begin
      if (bus.start) begin
        if (bus.gate_len != 0) begin
          m_busy = 1;
          m_left = int'(bus.gate_len);
          m_hits = 0;
        end else begin
          m_count = 0;
          m_ovf   = 0;
          m_done  = 1;
        end
      end
    end else begin
      m_hits += e;
      m_left--;
      if (m_left == 0) begin
        m_count = (m_hits > MAXC) ? MAXC : m_hits;
        m_ovf   = (m_hits > MAXC) ? 1 : 0;
        m_done  = 1;
        if (bus.cont && bus.gate_len != 0) begin
          m_left = int'(bus.gate_len);
          m_hits = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("count", 32'(bus.count), 32'(m_count));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic pulses(input int n);
    for (int p = 0; p < n; p++) begin
      bus.evt_in = 1'b1;
      repeat (2) tick();
      bus.evt_in = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic open_window(input int len);
    bus.gate_len = GATE_W'(len);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any edge.
  task automatic async_reset(input int hold);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    repeat (hold) tick();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.cont     = 1'b0;
    bus.gate_len = '0;
    bus.evt_in   = 1'b0;
    model_reset();

    // Reset hold, release with evt_in low, idle without start.
    repeat (3) tick();
    #2;
    rst = 1'b1;
    done_seen = 0;
    repeat (10) tick();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_no_done", 32'(done_seen), 32'd0);

    // 20-cycle window with three 2-cycle pulses.
    done_seen = 0;
    open_window(20);
    for (int c = 1; c <= 24; c++) begin
      bus.evt_in = (c == 3 || c == 4 || c == 8 || c == 9 || c == 13 || c == 14);
      tick();
    end
    check("w20_count", 32'(bus.count), 32'd3);
    check("w20_ovf", 32'(bus.overflow), 32'd0);
    check("w20_done_once", 32'(done_seen), 32'd1);
    repeat (5) tick();
    check("w20_hold", 32'(bus.count), 32'd3);

    // Saturation: 20 pulses into a 4-bit accumulator.
    done_seen = 0;
    open_window(80);
    pulses(20);
    repeat (3) tick();
    check("sat_count", 32'(bus.count), 32'(MAXC));
    check("sat_ovf", 32'(bus.overflow), 32'd1);
    check("sat_done_once", 32'(done_seen), 32'd1);

    open_window(40);
    pulses(5);
    repeat (22) tick();
    check("w40_count", 32'(bus.count), 32'd5);
    check("w40_ovf", 32'(bus.overflow), 32'd0);

    // Empty window.
    done_seen = 0;
    open_window(0);
    check("empty_done", 32'(bus.done), 32'd1);
    check("empty_busy", 32'(bus.busy), 32'd0);
    check("empty_count", 32'(bus.count), 32'd0);
    repeat (3) tick();
    check("empty_done_once", 32'(done_seen), 32'd1);

    // Continuous 10-cycle windows, start pulses during busy ignored.
    bus.cont  = 1'b1;
    done_seen = 0;
    open_window(10);
    for (int i = 0; i < 60; i++) begin
      bus.evt_in = ((i / 2) % 2) == 1;
      bus.start  = (i == 15 || i == 33);
      tick();
    end
    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus.evt_in = 1'b0;
    repeat (12) tick();
    check("cont_stopped", 32'(bus.busy), 32'd0);
    check("cont_done_cnt", 32'(done_seen), 32'd7);

    // Reset in the middle of a window with count=9 held.
    open_window(40);
    pulses(9);
    repeat (6) tick();
    check("pre_rst_count", 32'(bus.count), 32'd9);
    done_seen = 0;
    open_window(20);
    bus.evt_in = 1'b1;
    repeat (3) tick();
    bus.evt_in = 1'b0;
    repeat (3) tick();
    async_reset(3);
    repeat (25) tick();
    check("abort_no_done", 32'(done_seen), 32'd0);
    done_seen = 0;
    open_window(12);
    pulses(3);
    repeat (3) tick();
    check("post_rst_count", 32'(bus.count), 32'd3);
    check("post_rst_done", 32'(done_seen), 32'd1);

    // evt_in high across reset release yields exactly one edge.
    bus.evt_in = 1'b1;
    async_reset(2);
    open_window(5);
    repeat (8) tick();
    bus.evt_in = 1'b0;
    check("rel_high_count", 32'(bus.count), 32'd1);

    // Longest window the counter supports.
    done_seen = 0;
    open_window((1 << GATE_W) - 1);
    for (int i = 0; i < (1 << GATE_W) + 2; i++) begin
      bus.evt_in = ($urandom_range(0, 3) == 0);
      tick();
    end
    check("max_win_done", 32'(done_seen), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 2) == 0) bus.evt_in = ~bus.evt_in;
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.cont     = ($urandom_range(0, 3) == 0);
      bus.gate_len = GATE_W'($urandom_range(0, 12));
      if (i == 1234) async_reset(2);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gated_event_counter.md
Name: gated_event_counter

Overview:
- Counts rising edges of an asynchronous event input during a programmable window of clock cycles, then latches the total into a holding register.
- Sits upstream of the counter/register library. It turns raw external pulses into a registered count plus a one-cycle done strobe, for frequency and pulse measurement.
- Contains a two-flop synchroniser, an edge detector, a window down-counter, a saturating accumulator and a small control FSM.

Parameters:
- WIDTH, 8, width of the accumulator and of the count output.
- GATE_W, 16, width of the window-length input and of the internal window counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- start  in  1  request to open a window; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at window end.
- gate_len  in  GATE_W  window length in clock cycles; sampled when a window opens.
- evt_in  in  1  asynchronous event input.
- busy  out  1  high while a window is open (state COUNT).
- done  out  1  one-cycle strobe marking a new result.
- count  out  WIDTH  latched result of the last completed window.
- overflow  out  1  latched flag: the last window saturated.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Sync flops s1, s2, s3, window counter rem and accumulator acc are cleared.
  - busy=0, done=0, count=0, overflow=0.
- Synchroniser and edge detect:
  - s1<=evt_in, s2<=s1, s3<=s2 on every clock, in any state.
  - edge = s2 & ~s3; this is a combinational pulse, 1 cycle wide.
  - An evt_in rise set up before posedge N makes edge high in the cycle after posedge N+1.
  - If evt_in is high while rst is released, one edge pulse is generated; this is defined and legal.
- FSM states: IDLE, COUNT.
- IDLE, with start=1 at posedge P0:
  - gate_len != 0: rem<=gate_len, acc<=0, ovf_int<=0, state goes to COUNT (busy=1 from P0).
  - gate_len == 0: an empty window. count<=0, overflow<=0, done<=1 at P0, state stays IDLE, busy stays 0.
- COUNT, at every posedge:
  - rem<=rem-1.
  - If edge=1: if acc < 2^WIDTH-1 then acc<=acc+1, else ovf_int<=1 and acc holds.
- Window end, at the posedge where rem==1:
  - count<=acc plus the edge sampled at this posedge, saturating at 2^WIDTH-1.
  - overflow<=ovf_int, or 1 if this final increment saturates.
  - done<=1 for exactly one cycle.
  - If cont=1 and gate_len!=0: rem<=gate_len, acc<=0, ovf_int<=0, state stays COUNT (busy stays high, no gap cycle).
  - If cont=1 and gate_len==0: the result is latched as above, then state goes to IDLE.
  - Otherwise: state goes to IDLE.
- Window timing: edges are sampled at exactly gate_len posedges, P1..P_gate_len. done is high in the cycle following P_gate_len.
- start is ignored while busy=1, including the window-end posedge. Only cont restarts a window.
- count and overflow hold their values between windows. They change only at window end, on an empty-window start, or on reset.
- rem never underflows; the maximum window is 2^GATE_W-1 cycles.
- Reset mid-window:
  - The window is aborted with no done pulse, and count and overflow clear to 0.
  - After release the block is in IDLE and waits for start.
- done defaults to 0 in every cycle not listed above.

Test Plan:
- Reset hold, then release with evt_in=0 -> all outputs 0. busy stays 0 for 10 idle cycles with no start.
- WIDTH=8, gate_len=20, start pulse at P0; evt_in driven high for 2 cycles at cycles 3, 8, 13 after P0 -> busy high P0..P20, done high in one cycle after P20, count=3, overflow=0. count holds 3 afterwards.
- WIDTH=4, gate_len=80; 20 clean pulses, each 2 high and 2 low, inside the window -> count=15, overflow=1, exactly one done. A following 40-cycle window with 5 pulses -> count=5, overflow=0.
- gate_len=0, start=1 -> done in the cycle after the start posedge, count=0, busy never asserted.
- cont=1, gate_len=10, evt_in toggling every 2 cycles -> done every 10 cycles with no busy gap. Count of 2 or 3 per window, summing to the number of rises. Dropping cont stops after the current window. start pulses during busy have no effect.
- Assert rst at cycle 7 of a 20-cycle window with count=9 held from an earlier window -> count=0, overflow=0, busy=0, no done. A new start after release counts correctly.
